// File: rtl/aa_frame_streamer.sv
// -----------------------------------------------------------------------------
// aa_frame_streamer
//
// Reader side of the anti-aliasing frame buffer. On a start pulse it reads a
// SIZE x SIZE frame from the buffer's synchronous read port in raster order
// and emits it as a valid/ready pixel stream with sof/eol/eof markers. Reads
// are prefetched into a 2-entry output FIFO so a continuously ready sink gets
// one pixel per cycle.
//
// Ports:
//   sysclk   in   clock
//   reset_n  in   asynchronous active-low reset
//   start    in   single-cycle pulse, begin readout (only honoured in IDLE)
//   busy     out  frame readout in progress
//   rd_en    out  buffer read enable
//   rd_addr  out  buffer read address (row*SIZE + col)
//   rd_data  in   buffer read data, valid one cycle after rd_en
//   m_valid  out  output pixel valid
//   m_ready  in   downstream ready
//   m_data   out  output pixel
//   m_sof    out  pixel (0,0)
//   m_eol    out  last pixel of a line
//   m_eof    out  last pixel of the frame
//   done     out  single-cycle pulse after the last pixel handshake
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | issuing buffer reads until every address has been issued
// DRAIN | all reads issued, waiting for the eof pixel handshake
// DONE  | one-cycle done pulse, back to IDLE
// -----------------------------------------------------------------------------
module aa_frame_streamer #(
    parameter int PIX_W  = 8,
    parameter int SIZE   = 16,
    parameter int ADDR_W = $clog2(SIZE*SIZE)
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              done
);

    localparam int            CW       = $clog2(SIZE);
    localparam logic [CW-1:0] LAST_IDX = CW'(SIZE-1);
    localparam int            EW       = PIX_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, row_q;
    logic [ADDR_W-1:0] addr_q;
    logic              inflight_q;
    logic [2:0]        meta_q;
    logic [EW-1:0]     ent_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        cnt_q;

    logic              pop, push, issue, last_issue;
    logic [1:0]        occ_proj;
    logic [2:0]        issue_meta;
    logic [EW-1:0]     head;

    assign pop  = (cnt_q != 2'd0) && m_ready;
    assign push = inflight_q;

    // Occupancy the FIFO will hold after this edge, counting the read whose
    // data lands this cycle and crediting a pop happening this cycle. Issuing
    // only while this is below 2 guarantees the new read a slot next cycle
    // and still allows back-to-back reads when the sink is ready.
    assign occ_proj   = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue      = (state_q == S_RUN) && (occ_proj < 2'd2);
    assign last_issue = issue && (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign issue_meta = {(row_q == '0) && (col_q == '0), col_q == LAST_IDX, last_issue};
    assign head       = ent_q[rd_ptr_q];

    // state register
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_issue) state_d = S_DRAIN;
            S_DRAIN: if (pop && head[0]) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
        done    = (state_q == S_DONE);
        rd_en   = issue;
        rd_addr = addr_q;
        m_valid = (cnt_q != 2'd0);
        m_data  = head[EW-1:3];
        m_sof   = m_valid && head[2];
        m_eol   = m_valid && head[1];
        m_eof   = m_valid && head[0];
    end

    // fetch counters, in-flight tracking and output FIFO
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            meta_q     <= '0;
            ent_q[0]   <= '0;
            ent_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                col_q  <= '0;
                row_q  <= '0;
                addr_q <= '0;
            end else if (issue) begin
                if (last_issue) begin
                    col_q  <= '0;
                    row_q  <= '0;
                    addr_q <= '0;
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (col_q == LAST_IDX) begin
                        col_q <= '0;
                        row_q <= row_q + CW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
            end

            inflight_q <= issue;
            if (issue) begin
                meta_q <= issue_meta;
            end

            if (push) begin
                ent_q[wr_ptr_q] <= {rd_data, meta_q};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_aa_frame_streamer.sv
module tb_aa_frame_streamer;

    logic sysclk = 1'b0;
    logic reset_n = 1'b0;
    always #5 sysclk = ~sysclk;

    // 4x4 instance
    logic       start_a = 1'b0, m_ready_a = 1'b0;
    logic       busy_a, rd_en_a, m_valid_a, m_sof_a, m_eol_a, m_eof_a, done_a;
    logic [3:0] rd_addr_a;
    logic [7:0] rd_data_a, m_data_a;

    // 16x16 instance
    logic       start_b = 1'b0, m_ready_b = 1'b0;
    logic       busy_b, rd_en_b, m_valid_b, m_sof_b, m_eol_b, m_eof_b, done_b;
    logic [7:0] rd_addr_b;
    logic [7:0] rd_data_b, m_data_b;

    aa_frame_streamer #(.PIX_W(8), .SIZE(4)) dut_a (
        .sysclk(sysclk), .reset_n(reset_n), .start(start_a), .busy(busy_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
        .m_sof(m_sof_a), .m_eol(m_eol_a), .m_eof(m_eof_a), .done(done_a)
    );

    aa_frame_streamer #(.PIX_W(8), .SIZE(16)) dut_b (
        .sysclk(sysclk), .reset_n(reset_n), .start(start_b), .busy(busy_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
        .m_sof(m_sof_b), .m_eol(m_eol_b), .m_eof(m_eof_b), .done(done_b)
    );

    // buffer models: buffer[a] = a, synchronous read
    always @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a <= 8'd0;
            rd_data_b <= 8'd0;
        end else begin
            if (rd_en_a) rd_data_a <= {4'd0, rd_addr_a};
            if (rd_en_b) rd_data_b <= rd_addr_b;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // expected pixel stream of the 4x4 frame
    typedef struct {
        logic [7:0] data;
        logic       sof, eol, eof;
    } pix_t;
    pix_t exp_pix[16];

    // cycle-exact vectors of the basic frame, cycle 0 = start cycle
    typedef struct {
        int         cyc;
        logic       busy, rd_en, valid, done;
        logic       chk_data;
        logic [7:0] data;
        logic       chk_addr;
        logic [3:0] addr;
    } tv_t;
    tv_t tv[10];

    // monitor state
    int issued_a = 0, pix_a = 0, done_cnt_a = 0;
    int issued_b = 0, pix_b = 0, done_cnt_b = 0, eol_cnt_b = 0, eof_cnt_b = 0;
    int last_addr_b = -1;

    always @(negedge sysclk) begin
        #2;
        if (reset_n) begin
            if (rd_en_a) begin
                chk("a_rd_addr_order", rd_addr_a, issued_a);
                issued_a++;
            end
            if (m_valid_a) begin
                chk("a_pix_in_range", pix_a < 16, 1);
                if (pix_a < 16) begin
                    chk("a_m_data", m_data_a, exp_pix[pix_a].data);
                    chk("a_m_sof", m_sof_a, exp_pix[pix_a].sof);
                    chk("a_m_eol", m_eol_a, exp_pix[pix_a].eol);
                    chk("a_m_eof", m_eof_a, exp_pix[pix_a].eof);
                end
                if (m_ready_a) pix_a++;
            end
            chk("a_occupancy_le2", (issued_a - pix_a) <= 2, 1);
            if (done_a) done_cnt_a++;

            if (rd_en_b) begin
                chk("b_rd_addr_order", rd_addr_b, issued_b);
                last_addr_b = rd_addr_b;
                issued_b++;
            end
            if (m_valid_b && m_ready_b) begin
                chk("b_m_data", m_data_b, pix_b % 256);
                chk("b_m_sof", m_sof_b, pix_b == 0);
                chk("b_m_eof", m_eof_b, pix_b == 255);
                if (m_eol_b) begin
                    chk("b_eol_pos", pix_b % 16, 15);
                    eol_cnt_b++;
                end
                if (m_eof_b) eof_cnt_b++;
                pix_b++;
            end
            chk("b_occupancy_le2", (issued_b - pix_b) <= 2, 1);
            if (done_b) done_cnt_b++;
        end
    end

    task automatic clear_a();
        issued_a = 0; pix_a = 0; done_cnt_a = 0;
    endtask

    task automatic check_zero_a(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_rd_en"}, rd_en_a, 0);
        chk({tag, "_rd_addr"}, rd_addr_a, 0);
        chk({tag, "_m_valid"}, m_valid_a, 0);
        chk({tag, "_m_data"}, m_data_a, 0);
        chk({tag, "_markers"}, {m_sof_a, m_eol_a, m_eof_a}, 0);
        chk({tag, "_done"}, done_a, 0);
    endtask

    // mode 0: ready=1 with timing vectors, 1: ready 1,0,0,1 pattern,
    // 2: stalled 21 cycles then ready, 3: extra starts, 4: reset mid-frame
    task automatic run_a(input int mode, input int bound);
        int  post;
        bit  seen_done, sent2, fin;
        post = 0; seen_done = 0; sent2 = 0; fin = 0;
        for (int c = 0; c <= bound && !fin; c++) begin
            @(negedge sysclk);
            start_a = (c == 0);
            if (mode == 3 && !sent2 && pix_a == 4) begin
                start_a = 1'b1;
                sent2 = 1'b1;
            end
            if (mode == 3 && done_a) start_a = 1'b1;
            case (mode)
                1:       m_ready_a = (c % 4 == 0) || (c % 4 == 3);
                2:       m_ready_a = (c > 20);
                default: m_ready_a = 1'b1;
            endcase
            if (mode == 2 && c == 20) begin
                chk("stall_reads_issued", issued_a, 2);
                chk("stall_m_valid", m_valid_a, 1);
                chk("stall_m_data", m_data_a, 0);
                chk("stall_m_sof", m_sof_a, 1);
            end
            #1;
            if (mode == 0) begin
                for (int k = 0; k < 10; k++) begin
                    if (tv[k].cyc == c) begin
                        chk("tv_busy", busy_a, tv[k].busy);
                        chk("tv_rd_en", rd_en_a, tv[k].rd_en);
                        chk("tv_m_valid", m_valid_a, tv[k].valid);
                        chk("tv_done", done_a, tv[k].done);
                        if (tv[k].chk_data) chk("tv_m_data", m_data_a, tv[k].data);
                        if (tv[k].chk_addr) chk("tv_rd_addr", rd_addr_a, tv[k].addr);
                    end
                end
            end
            if (mode == 4 && pix_a == 7) begin
                #2;
                reset_n = 1'b0;
                #1;
                check_zero_a("midreset");
                start_a = 1'b0;
                fin = 1'b1;
            end
            if (done_a) seen_done = 1'b1;
            if (seen_done) begin
                post++;
                if (post > 4) fin = 1'b1;
            end
        end
        start_a = 1'b0;
        if (mode != 4) chk("frame_completed_in_bound", seen_done, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            exp_pix[i].data = 8'(i);
            exp_pix[i].sof  = (i == 0);
            exp_pix[i].eol  = (i % 4 == 3);
            exp_pix[i].eof  = (i == 15);
        end
        //        cyc busy rd  vld done  cd  data   ca  addr
        tv[0] = '{0,  0,  0,  0,  0,   0, 8'd0,  1, 4'd0};
        tv[1] = '{1,  1,  1,  0,  0,   0, 8'd0,  1, 4'd0};
        tv[2] = '{2,  1,  1,  0,  0,   0, 8'd0,  1, 4'd1};
        tv[3] = '{3,  1,  1,  1,  0,   1, 8'd0,  1, 4'd2};
        tv[4] = '{10, 1,  1,  1,  0,   1, 8'd7,  1, 4'd9};
        tv[5] = '{16, 1,  1,  1,  0,   1, 8'd13, 1, 4'd15};
        tv[6] = '{17, 1,  0,  1,  0,   1, 8'd14, 0, 4'd0};
        tv[7] = '{18, 1,  0,  1,  0,   1, 8'd15, 0, 4'd0};
        tv[8] = '{19, 0,  0,  0,  1,   0, 8'd0,  0, 4'd0};
        tv[9] = '{20, 0,  0,  0,  0,   0, 8'd0,  0, 4'd0};

        #1;
        check_zero_a("reset");
        #11;
        reset_n = 1'b1;

        // basic frame
        clear_a();
        run_a(0, 60);
        chk("basic_pixels", pix_a, 16);
        chk("basic_done_pulses", done_cnt_a, 1);

        // backpressure 1,0,0,1
        clear_a();
        run_a(1, 200);
        chk("bp_pixels", pix_a, 16);
        chk("bp_reads", issued_a, 16);
        chk("bp_done_pulses", done_cnt_a, 1);

        // downstream stall at start
        clear_a();
        run_a(2, 200);
        chk("stall_pixels", pix_a, 16);
        chk("stall_done_pulses", done_cnt_a, 1);

        // start ignored while busy and in the DONE cycle
        clear_a();
        run_a(3, 200);
        chk("ign_pixels", pix_a, 16);
        chk("ign_reads", issued_a, 16);
        chk("ign_done_pulses", done_cnt_a, 1);
        chk("ign_busy_after_done", busy_a, 0);
        chk("ign_rd_en_after_done", rd_en_a, 0);

        // reset mid-frame, then a fresh frame
        clear_a();
        run_a(4, 200);
        chk("midreset_no_done", done_cnt_a, 0);
        @(negedge sysclk);
        @(negedge sysclk);
        check_zero_a("held_reset");
        reset_n = 1'b1;
        clear_a();
        run_a(0, 60);
        chk("restart_pixels", pix_a, 16);
        chk("restart_done_pulses", done_cnt_a, 1);

        // 16x16 with random ready
        begin
            int  post;
            bit  seen, fin;
            post = 0; seen = 0; fin = 0;
            for (int c = 0; c < 3000 && !fin; c++) begin
                @(negedge sysclk);
                start_b   = (c == 0);
                m_ready_b = 1'($urandom_range(0, 1));
                #1;
                if (done_b) seen = 1'b1;
                if (seen) begin
                    post++;
                    if (post > 3) fin = 1'b1;
                end
            end
            start_b = 1'b0;
            chk("max_completed_in_bound", seen, 1);
            chk("max_pixels", pix_b, 256);
            chk("max_reads", issued_b, 256);
            chk("max_eol_count", eol_cnt_b, 16);
            chk("max_eof_count", eof_cnt_b, 1);
            chk("max_last_addr", last_addr_b, 255);
            chk("max_done_pulses", done_cnt_b, 1);
            chk("max_busy_after", busy_b, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
